// File: rtl/mem_bus_if.sv
// mem_bus_if: bus master for the MEM stage's memory-mapped accesses.
// Turns a level-held MEM access strobe into a request / grant / address
// strobe / ready handshake on the shared bus. The pipeline is stalled while
// the access is in flight. Read data and a timeout error flag go back to MEM
// when the access ends.
module mem_bus_if #(
  parameter int unsigned TIMEOUT = 16  // WAIT cycles without ready before abort (1..255)
) (
  input  logic        clk,
  input  logic        reset,

  // MEM stage side
  input  logic        mem_as,
  input  logic        mem_rw,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        flush,
  output logic        mem_busy,
  output logic [31:0] mem_rd_data,
  output logic        mem_err,

  // Shared bus side
  output logic        bus_req,
  input  logic        bus_grnt,
  output logic        bus_as,
  output logic        bus_rw,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACCESS,
    S_WAIT
  } state_t;

  // WAIT-cycle counter value seen in the last WAIT cycle that is allowed
  // before the abort fires.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_nxt;
  logic [31:0] rd_data_q;

  // Single-cycle events decoded from the current state and inputs.
  logic        start;     // IDLE accepts a new access
  logic        done;      // slave ready in ACCESS or WAIT
  logic        abort;     // timeout reached in WAIT

  // Next-state, stall and event decode.
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    start        = 1'b0;
    done         = 1'b0;
    abort        = 1'b0;
    mem_busy     = 1'b0;

    case (state)
      S_IDLE: begin
        // A flushed access never touches the bus.
        if (mem_as && !flush) begin
          start     = 1'b1;
          mem_busy  = 1'b1;
          state_nxt = S_REQ;
        end
      end

      S_REQ: begin
        // No timeout here: the arbiter will eventually grant.
        mem_busy = 1'b1;
        if (bus_grnt) begin
          state_nxt = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (bus_rdy) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          mem_busy     = 1'b1;
          wait_cnt_nxt = 8'd0;
          state_nxt    = S_WAIT;
        end
      end

      S_WAIT: begin
        // Ready wins over the timeout when both land in the same cycle.
        if (bus_rdy) begin
          done         = 1'b1;
          wait_cnt_nxt = 8'd0;
          state_nxt    = S_IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          abort        = 1'b1;
          wait_cnt_nxt = 8'd0;
          state_nxt    = S_IDLE;
        end else begin
          mem_busy     = 1'b1;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and timeout counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Capture the request when it is accepted. The bus address, direction and
  // write data hold from then until the next accepted access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_rw      <= 1'b1;
      bus_addr    <= 32'd0;
      bus_wr_data <= 32'd0;
    end else if (start) begin
      bus_rw      <= mem_rw;
      bus_addr    <= mem_addr;
      bus_wr_data <= mem_wr_data;
    end
  end

  // Returned read data: loaded on a read completion, cleared on abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= 32'd0;
    end else if (abort) begin
      rd_data_q <= 32'd0;
    end else if (done && bus_rw) begin
      rd_data_q <= bus_rd_data;
    end
  end

  // Bus control is decoded from state only, with no combinational path
  // from any bus input.
  assign bus_req = (state != S_IDLE);
  assign bus_as  = (state == S_ACCESS);

  // MEM-side results. Read data bypasses the register in the completion
  // cycle so MEM sees it without an extra stall cycle.
  assign mem_err     = abort;
  assign mem_rd_data = (done && bus_rw) ? bus_rd_data : rd_data_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: table-driven bench for mem_bus_if with a reactive
// arbiter/slave model and a scoreboard of expected transaction results.
module tb_mem_bus_if;

  localparam int unsigned TO = 4;
  localparam int NEVER = 255;   // wait-state count meaning "slave never ready"

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_as;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        flush;
  logic        mem_busy;
  logic [31:0] mem_rd_data;
  logic        mem_err;
  logic        bus_req;
  logic        bus_grnt;
  logic        bus_as;
  logic        bus_rw;
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy;

  mem_bus_if #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_as      (mem_as),
    .mem_rw      (mem_rw),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .flush       (flush),
    .mem_busy    (mem_busy),
    .mem_rd_data (mem_rd_data),
    .mem_err     (mem_err),
    .bus_req     (bus_req),
    .bus_grnt    (bus_grnt),
    .bus_as      (bus_as),
    .bus_rw      (bus_rw),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_rdy     (bus_rdy)
  );

  always #5 clk = ~clk;

  // One access: stimulus and slave behaviour plus its expected results.
  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_delay;   // REQ cycle (1-based) in which grant is given
    int          waits;       // WAIT cycles before ready (NEVER = no ready)
    logic        flush_req;   // drive flush while in REQ
    logic [31:0] exp_rd;      // mem_rd_data in the final cycle
    logic [31:0] exp_hold;    // mem_rd_data in the following cycle
    int          exp_req;     // cycles with bus_req high
    int          exp_busy;    // cycles with mem_busy high
    int          exp_err;     // cycles with mem_err high
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] hold;
    int          req;
    int          busy;
    int          err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int gnt_delay, input int waits,
                              input logic flush_req, input logic [31:0] exp_rd,
                              input logic [31:0] exp_hold, input int exp_req,
                              input int exp_busy, input int exp_err);
    vec_t v;
    v.rw = rw; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.gnt_delay = gnt_delay; v.waits = waits; v.flush_req = flush_req;
    v.exp_rd = exp_rd; v.exp_hold = exp_hold; v.exp_req = exp_req;
    v.exp_busy = exp_busy; v.exp_err = exp_err;
    return v;
  endfunction

  // Drive one access, act as arbiter and slave cycle by cycle, then compare
  // the observed results against the scoreboard entry.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t        e;
    int          req_n = 0, busy_n = 0, err_n = 0, as_n = 0, reqph = 0, wph = 0;
    bit          accessed = 0, done = 0;
    logic [31:0] rd_at_done = 32'd0;

    sb.push_back('{rd: v.exp_rd, hold: v.exp_hold, req: v.exp_req,
                   busy: v.exp_busy, err: v.exp_err});

    @(posedge clk); #1;
    mem_as = 1'b1; mem_rw = v.rw; mem_addr = v.addr; mem_wr_data = v.wdata;
    flush = 1'b0; bus_grnt = 1'b0; bus_rdy = 1'b0;

    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (bus_req)  req_n++;
      if (mem_busy) busy_n++;
      if (mem_err)  err_n++;
      if (bus_as) begin
        as_n++;
        check({tag, " bus_addr"},    bus_addr,    v.addr);
        check({tag, " bus_rw"},      {31'd0, bus_rw}, {31'd0, v.rw});
        if (!v.rw) check({tag, " bus_wr_data"}, bus_wr_data, v.wdata);
      end
      if (bus_req && !mem_busy) begin
        done = 1;
        rd_at_done = mem_rd_data;
        check({tag, " addr held"}, bus_addr, v.addr);
      end

      @(posedge clk); #1;
      if (done) begin
        mem_as = 1'b0; flush = 1'b0; bus_grnt = 1'b0; bus_rdy = 1'b0;
      end else if (bus_as) begin
        accessed    = 1;
        flush       = 1'b0;
        bus_rdy     = (v.waits == 0);
        bus_rd_data = (v.waits == 0) ? v.rdata : $urandom;
      end else if (bus_req && !accessed) begin
        reqph++;
        flush    = v.flush_req;
        bus_grnt = (reqph >= v.gnt_delay);
      end else if (bus_req) begin
        wph++;
        bus_rdy     = (wph == v.waits);
        bus_rd_data = (wph == v.waits) ? v.rdata : $urandom;
      end
    end

    if (!done) begin
      check({tag, " completion within budget"}, 32'd0, 32'd1);
      sb.delete();
      return;
    end

    e = sb.pop_front();
    check({tag, " mem_rd_data"}, rd_at_done, e.rd);
    check({tag, " bus_req cycles"}, 32'(req_n), 32'(e.req));
    check({tag, " mem_busy cycles"}, 32'(busy_n), 32'(e.busy));
    check({tag, " mem_err cycles"}, 32'(err_n), 32'(e.err));
    check({tag, " bus_as cycles"}, 32'(as_n), 32'd1);

    @(negedge clk);
    check({tag, " bus_req after end"}, {31'd0, bus_req}, 32'd0);
    check({tag, " mem_rd_data held"}, mem_rd_data, e.hold);
  endtask

  initial begin
    reset = 1'b1; mem_as = 1'b0; mem_rw = 1'b0; mem_addr = 32'd0;
    mem_wr_data = 32'd0; flush = 1'b0; bus_grnt = 1'b0; bus_rdy = 1'b0;
    bus_rd_data = 32'd0;

    //                rw    addr          wdata         rdata         gnt wait   flsh exp_rd        exp_hold      req busy err
    vecs[0] = mk(1'b1, 32'h8000_0004, 32'h0,        32'h1234_5678, 1, 0,     1'b0, 32'h1234_5678, 32'h1234_5678, 2, 2, 0);
    vecs[1] = mk(1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0,        3, 2,     1'b0, 32'h1234_5678, 32'h1234_5678, 6, 6, 0);
    vecs[2] = mk(1'b1, 32'h8000_0010, 32'h0,        32'h0,         1, NEVER, 1'b0, 32'h1234_5678, 32'h0,         6, 6, 1);
    vecs[3] = mk(1'b1, 32'h8000_0014, 32'h0,        32'hA5A5_A5A5, 1, 4,     1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 6, 6, 0);
    vecs[4] = mk(1'b1, 32'h8000_0018, 32'h0,        32'h0F0F_0000, 2, 1,     1'b1, 32'h0F0F_0000, 32'h0F0F_0000, 4, 4, 0);
    vecs[5] = mk(1'b0, 32'h8000_0020, 32'h0000_0001, 32'h0,        1, 3,     1'b0, 32'h0F0F_0000, 32'h0F0F_0000, 5, 5, 0);
    vecs[6] = mk(1'b1, 32'hFFFF_FFFC, 32'h0,        32'hFFFF_FFFF, 1, 0,     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 2, 0);

    // Reset state.
    #3;
    check("rst bus_req",     {31'd0, bus_req},  32'd0);
    check("rst bus_as",      {31'd0, bus_as},   32'd0);
    check("rst bus_rw",      {31'd0, bus_rw},   32'd1);
    check("rst bus_addr",    bus_addr,          32'd0);
    check("rst bus_wr_data", bus_wr_data,       32'd0);
    check("rst mem_rd_data", mem_rd_data,       32'd0);
    check("rst mem_err",     {31'd0, mem_err},  32'd0);
    check("rst mem_busy",    {31'd0, mem_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Flush while IDLE: access is dropped, nothing reaches the bus.
    @(posedge clk); #1;
    mem_as = 1'b1; mem_rw = 1'b1; mem_addr = 32'h8000_0040; flush = 1'b1;
    @(negedge clk);
    check("idle flush mem_busy", {31'd0, mem_busy}, 32'd0);
    @(posedge clk); #1;
    mem_as = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle flush bus_req", {31'd0, bus_req}, 32'd0);

    // Reset asserted in the middle of WAIT.
    @(posedge clk); #1;
    mem_as = 1'b1; mem_rw = 1'b1; mem_addr = 32'h8000_00F0; bus_grnt = 1'b0; bus_rdy = 1'b0;
    @(posedge clk); #1; bus_grnt = 1'b1;   // REQ
    @(posedge clk); #1;                    // ACCESS, not ready
    @(posedge clk); #1;                    // WAIT 1
    @(posedge clk); #1;                    // WAIT 2
    check("pre-reset bus_req", {31'd0, bus_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid rst bus_req",     {31'd0, bus_req}, 32'd0);
    check("mid rst bus_as",      {31'd0, bus_as},  32'd0);
    check("mid rst bus_rw",      {31'd0, bus_rw},  32'd1);
    check("mid rst bus_addr",    bus_addr,         32'd0);
    check("mid rst mem_rd_data", mem_rd_data,      32'd0);
    check("mid rst mem_err",     {31'd0, mem_err}, 32'd0);
    mem_as = 1'b0; bus_grnt = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_vec(mk(1'b1, 32'h8000_0008, 32'h0, 32'h3C3C_3C3C, 1, 1, 1'b0,
               32'h3C3C_3C3C, 32'h3C3C_3C3C, 3, 3, 0), "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
